tdsp_ds_arb: RTL and testbench

TDSP_DS_ARB -- requirements
Module: tdsp_ds_arb

---
 rtl/tdsp_ds_pkg.sv | 26 ++
 rtl/tdsp_ds_arb_if.sv | 41 ++++
 rtl/tdsp_ds_arb_fsm.sv | 97 +++++++++
 rtl/tdsp_ds_arb.sv | 95 +++++++++
 tb/tb_tdsp_ds_arb.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/tdsp_ds_pkg.sv
// Shared types and constants for the TDSP data-space arbiter: arbiter states,
// bank-mode encodings, address-region prefixes and port register addresses.
package tdsp_ds_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DMA_PEND = 2'd1,
        ST_DMA_OWN  = 2'd2,
        ST_RELEASE  = 2'd3
    } arb_state_e;

    // Bank-mode encodings; 11 behaves exactly like 00.
    localparam logic [1:0] MODE_DMA_PREV     = 2'b00;
    localparam logic [1:0] MODE_TDSP         = 2'b01;
    localparam logic [1:0] MODE_TDSP_AUTO    = 2'b10;
    localparam logic [1:0] MODE_DMA_PREV_ALT = 2'b11;

    // Region prefixes, matched against the top address bits.
    localparam logic [1:0] PFX_SCRATCH_A = 2'b10;
    localparam logic [2:0] PFX_SCRATCH_B = 3'b110;
    localparam logic [3:0] PFX_RCC       = 4'b1110;

    localparam logic [2:0] PORT_REG_MODE = 3'd0;
    localparam logic [2:0] PORT_REG_BANK = 3'd1;

endpackage

// File: rtl/tdsp_ds_arb_if.sv
// TDSP/DMA side signals of the data-space arbiter, bundled with modports for
// the driving side (master) and the arbiter (slave).
interface tdsp_ds_arb_if #(
    parameter int ADDR_W = 8,
    parameter int BANK_W = 2
);

    logic [ADDR_W-1:0]        address;
    logic                     as;
    logic                     read;
    logic                     write;
    logic [2:0]               port_address;
    logic                     port_as;
    logic [7:0]               port_data;
    logic [BANK_W-1:0]        dma_bank;
    logic                     bus_request_in;
    logic                     bus_grant_out;
    logic                     t_wait;
    logic                     t_write_ds;
    logic                     t_read_ds;
    logic                     t_write_d;
    logic                     t_read_d;
    logic                     t_write_rcc;
    logic [BANK_W+ADDR_W-2:0] t_address_ds;
    logic [1:0]               bank_mode;

    modport master (
        output address, as, read, write, port_address, port_as, port_data,
        output dma_bank, bus_request_in,
        input  bus_grant_out, t_wait, t_write_ds, t_read_ds, t_write_d,
        input  t_read_d, t_write_rcc, t_address_ds, bank_mode
    );

    modport slave (
        input  address, as, read, write, port_address, port_as, port_data,
        input  dma_bank, bus_request_in,
        output bus_grant_out, t_wait, t_write_ds, t_read_ds, t_write_d,
        output t_read_d, t_write_rcc, t_address_ds, bank_mode
    );

endinterface

// File: rtl/tdsp_ds_arb_fsm.sv
// Sample-memory arbiter between the TDSP and the DMA controller, with a burst
// counter that forces a one-cycle release when the TDSP has waited too long.
module tdsp_ds_arb_fsm
    import tdsp_ds_pkg::*;
#(
    parameter int MAX_BURST = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_bus_req,
    input  logic i_samp_acc,
    output logic o_grant,
    output logic o_t_wait
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_grant;
    logic             w_t_wait;

    // The pending->own move only fires once the sample access has ended, so
    // it can never coincide with a sample access; only DMA_OWN stalls.
    assign w_t_wait = i_samp_acc & (r_state == ST_DMA_OWN);
    assign o_t_wait = w_t_wait;
    assign o_grant  = r_grant;

    // State, burst counter and registered grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_grant <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (i_bus_req && i_samp_acc) begin
                        r_state <= ST_DMA_PEND;
                        r_grant <= 1'b0;
                    end else if (i_bus_req) begin
                        r_state <= ST_DMA_OWN;
                        r_grant <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_grant <= 1'b0;
                    end
                end
                ST_DMA_PEND: begin
                    r_cnt <= '0;
                    if (!i_bus_req) begin
                        r_state <= ST_IDLE;
                        r_grant <= 1'b0;
                    end else if (!i_samp_acc) begin
                        r_state <= ST_DMA_OWN;
                        r_grant <= 1'b1;
                    end else begin
                        r_state <= ST_DMA_PEND;
                        r_grant <= 1'b0;
                    end
                end
                ST_DMA_OWN: begin
                    if (!i_bus_req) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_grant <= 1'b0;
                    end else if (w_t_wait && (r_cnt == CNT_LAST)) begin
                        r_state <= ST_RELEASE;
                        r_cnt   <= '0;
                        r_grant <= 1'b0;
                    end else if (w_t_wait) begin
                        r_state <= ST_DMA_OWN;
                        r_cnt   <= r_cnt + CNT_W'(1);
                        r_grant <= 1'b1;
                    end else begin
                        r_state <= ST_DMA_OWN;
                        r_cnt   <= '0;
                        r_grant <= 1'b1;
                    end
                end
                ST_RELEASE: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_grant <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_grant <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/tdsp_ds_arb.sv
// TDSP data-space front end: region decode, bank-extended sample addressing
// with port-programmed bank registers, and the sample-memory arbiter.
module tdsp_ds_arb
    import tdsp_ds_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BANK_W    = 2,
    parameter int MAX_BURST = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    tdsp_ds_arb_if.slave   bus
);

    logic [1:0]        r_bank_mode;
    logic [BANK_W-1:0] r_tdsp_bank;
    logic [BANK_W-1:0] w_bank;
    logic [BANK_W-1:0] w_dma_prev;
    logic              w_sample;
    logic              w_scratch;
    logic              w_rcc;
    logic              w_rcc_last;
    logic              w_samp_acc;
    logic              w_t_wait;
    logic              w_grant;
    logic              w_t_write_rcc;
    logic              w_port_wr;
    logic              w_unused_bits;

    assign w_sample   = ~bus.address[ADDR_W-1];
    assign w_scratch  = (bus.address[ADDR_W-1 -: 2] == PFX_SCRATCH_A) |
                        (bus.address[ADDR_W-1 -: 3] == PFX_SCRATCH_B);
    assign w_rcc      = (bus.address[ADDR_W-1 -: 4] == PFX_RCC);
    assign w_rcc_last = &bus.address[ADDR_W-5:0];
    assign w_samp_acc = w_sample & bus.as;
    assign w_port_wr  = bus.port_as & bus.write;
    assign w_dma_prev = bus.dma_bank - BANK_W'(1);
    assign w_unused_bits = ^bus.port_data;

    assign w_t_write_rcc   = w_rcc & bus.as & bus.write;
    assign bus.t_write_rcc = w_t_write_rcc;
    assign bus.t_write_d   = w_scratch & bus.as & bus.write;
    assign bus.t_read_d    = w_scratch & bus.as & bus.read;
    assign bus.t_write_ds  = w_samp_acc & bus.write & ~w_t_wait;
    assign bus.t_read_ds   = w_samp_acc & bus.read & ~w_t_wait;
    assign bus.t_wait      = w_t_wait;
    assign bus.bus_grant_out = w_grant;
    assign bus.bank_mode   = r_bank_mode;
    assign bus.t_address_ds = {w_bank, bus.address[ADDR_W-2:0]};

    tdsp_ds_arb_fsm #(
        .MAX_BURST (MAX_BURST)
    ) u_fsm (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_bus_req  (bus.bus_request_in),
        .i_samp_acc (w_samp_acc),
        .o_grant    (w_grant),
        .o_t_wait   (w_t_wait)
    );

    // Bank selection from the current mode.
    always_comb begin
        w_bank = w_dma_prev;
        case (r_bank_mode)
            MODE_DMA_PREV:     w_bank = w_dma_prev;
            MODE_TDSP:         w_bank = r_tdsp_bank;
            MODE_TDSP_AUTO:    w_bank = r_tdsp_bank;
            MODE_DMA_PREV_ALT: w_bank = w_dma_prev;
            default:           w_bank = w_dma_prev;
        endcase
    end

    // Port-programmed mode/bank registers; a port write beats auto-increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bank_mode <= 2'b00;
            r_tdsp_bank <= '0;
        end else begin
            if (w_port_wr && (bus.port_address == PORT_REG_MODE)) begin
                r_bank_mode <= bus.port_data[1:0];
            end else begin
                r_bank_mode <= r_bank_mode;
            end
            if (w_port_wr && (bus.port_address == PORT_REG_BANK)) begin
                r_tdsp_bank <= bus.port_data[BANK_W-1:0];
            end else if ((r_bank_mode == MODE_TDSP_AUTO) && w_t_write_rcc && w_rcc_last) begin
                r_tdsp_bank <= r_tdsp_bank + BANK_W'(1);
            end else begin
                r_tdsp_bank <= r_tdsp_bank;
            end
        end
    end

endmodule

// File: tb/tb_tdsp_ds_arb.sv
// Directed bench for tdsp_ds_arb: a decode vector table plus hand-written
// sequences for bank registers, arbitration, burst release and reset.
module tb_tdsp_ds_arb;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    tdsp_ds_arb_if #(.ADDR_W(8), .BANK_W(2)) bus_if ();

    tdsp_ds_arb #(
        .ADDR_W    (8),
        .BANK_W    (2),
        .MAX_BURST (4)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    // strb = {t_write_ds, t_read_ds, t_write_d, t_read_d, t_write_rcc}
    typedef struct {
        logic [7:0] addr;
        logic       as_v;
        logic       rd;
        logic       wr;
        logic [1:0] db;
        logic [4:0] strb;
        logic [8:0] taddr;
    } vec_t;

    vec_t vecs [10];
    int n_run  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] strobes();
        return {bus_if.t_write_ds, bus_if.t_read_ds, bus_if.t_write_d,
                bus_if.t_read_d, bus_if.t_write_rcc};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_tdsp();
        bus_if.as      = 1'b0;
        bus_if.read    = 1'b0;
        bus_if.write   = 1'b0;
        bus_if.port_as = 1'b0;
    endtask

    task automatic tdsp_acc(input logic [7:0] a, input logic rd, input logic wr);
        bus_if.address = a;
        bus_if.as      = 1'b1;
        bus_if.read    = rd;
        bus_if.write   = wr;
    endtask

    task automatic port_wr(input logic [2:0] pa, input logic [7:0] pd);
        bus_if.port_as      = 1'b1;
        bus_if.write        = 1'b1;
        bus_if.port_address = pa;
        bus_if.port_data    = pd;
        step();
        clear_tdsp();
    endtask

    initial begin
        vecs[0] = '{8'h10, 1'b1, 1'b1, 1'b0, 2'd2, 5'b01000, 9'h090};
        vecs[1] = '{8'h10, 1'b1, 1'b0, 1'b1, 2'd0, 5'b10000, 9'h190};
        vecs[2] = '{8'h80, 1'b1, 1'b1, 1'b0, 2'd2, 5'b00010, 9'h080};
        vecs[3] = '{8'hC5, 1'b1, 1'b0, 1'b1, 2'd2, 5'b00100, 9'h0C5};
        vecs[4] = '{8'hE3, 1'b1, 1'b0, 1'b1, 2'd1, 5'b00001, 9'h063};
        vecs[5] = '{8'hE3, 1'b1, 1'b1, 1'b0, 2'd1, 5'b00000, 9'h063};
        vecs[6] = '{8'hF0, 1'b1, 1'b0, 1'b1, 2'd3, 5'b00000, 9'h170};
        vecs[7] = '{8'h10, 1'b0, 1'b1, 1'b0, 2'd2, 5'b00000, 9'h090};
        vecs[8] = '{8'h7F, 1'b1, 1'b0, 1'b1, 2'd1, 5'b10000, 9'h07F};
        vecs[9] = '{8'hBF, 1'b1, 1'b1, 1'b0, 2'd0, 5'b00010, 9'h1BF};

        reset_n               = 1'b0;
        bus_if.address        = 8'h00;
        bus_if.port_address   = 3'd0;
        bus_if.port_data      = 8'h00;
        bus_if.dma_bank       = 2'd0;
        bus_if.bus_request_in = 1'b0;
        clear_tdsp();
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", 32'(bus_if.bus_grant_out), 32'h0);
        check("rst_wait",  32'(bus_if.t_wait),        32'h0);
        check("rst_mode",  32'(bus_if.bank_mode),     32'h0);
        reset_n = 1'b1;
        step();

        // Region decode and mode-00 bank addressing
        for (int i = 0; i < 10; i++) begin
            bus_if.address  = vecs[i].addr;
            bus_if.as       = vecs[i].as_v;
            bus_if.read     = vecs[i].rd;
            bus_if.write    = vecs[i].wr;
            bus_if.dma_bank = vecs[i].db;
            #1;
            check($sformatf("vec%0d_strb", i),  32'(strobes()),            32'(vecs[i].strb));
            check($sformatf("vec%0d_taddr", i), 32'(bus_if.t_address_ds), 32'(vecs[i].taddr));
            clear_tdsp();
            #1;
        end
        step();

        // Port registers: mode 01, tdsp_bank 3
        port_wr(3'd0, 8'h01);
        port_wr(3'd1, 8'h03);
        check("b_mode", 32'(bus_if.bank_mode), 32'h1);
        tdsp_acc(8'h05, 1'b1, 1'b0);
        #1;
        check("b_taddr", 32'(bus_if.t_address_ds), 32'h185);
        check("b_strb",  32'(strobes()),           32'h08);
        clear_tdsp();

        // Mode 10 auto-increment only on the last rcc address, with wrap
        port_wr(3'd0, 8'h02);
        check("c_mode", 32'(bus_if.bank_mode), 32'h2);
        tdsp_acc(8'hEE, 1'b0, 1'b1);
        #1;
        check("c_rcc_strb", 32'(strobes()), 32'h01);
        step();
        clear_tdsp();
        tdsp_acc(8'h00, 1'b1, 1'b0);
        #1;
        check("c_no_inc", 32'(bus_if.t_address_ds), 32'h180);
        clear_tdsp();
        tdsp_acc(8'hEF, 1'b0, 1'b1);
        step();
        clear_tdsp();
        tdsp_acc(8'h00, 1'b1, 1'b0);
        #1;
        check("c_wrap", 32'(bus_if.t_address_ds), 32'h000);
        clear_tdsp();
        tdsp_acc(8'hEF, 1'b0, 1'b1);
        bus_if.port_as      = 1'b1;
        bus_if.port_address = 3'd1;
        bus_if.port_data    = 8'h02;
        step();
        clear_tdsp();
        tdsp_acc(8'h00, 1'b1, 1'b0);
        #1;
        check("c_port_wins", 32'(bus_if.t_address_ds), 32'h100);
        clear_tdsp();
        step();

        // DMA request during a TDSP sample read is held off until as falls
        tdsp_acc(8'h10, 1'b1, 1'b0);
        bus_if.bus_request_in = 1'b1;
        #1;
        check("d_idle_grant", 32'(bus_if.bus_grant_out), 32'h0);
        check("d_idle_rd",    32'(bus_if.t_read_ds),     32'h1);
        step();
        check("d_pend_grant", 32'(bus_if.bus_grant_out), 32'h0);
        check("d_pend_wait",  32'(bus_if.t_wait),        32'h0);
        check("d_pend_rd",    32'(bus_if.t_read_ds),     32'h1);
        clear_tdsp();
        #1;
        check("d_fall_grant", 32'(bus_if.bus_grant_out), 32'h0);
        step();
        check("d_own_grant",  32'(bus_if.bus_grant_out), 32'h1);

        // Burst limit: a gap clears the counter, then 4 waits force a release
        tdsp_acc(8'h10, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            #1;
            check($sformatf("e_pre_wait%0d", i), 32'(bus_if.t_wait), 32'h1);
            step();
        end
        clear_tdsp();
        #1;
        check("e_gap_wait", 32'(bus_if.t_wait), 32'h0);
        step();
        tdsp_acc(8'h10, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("e_wait%0d", i),  32'(bus_if.t_wait),        32'h1);
            check($sformatf("e_grant%0d", i), 32'(bus_if.bus_grant_out), 32'h1);
            check($sformatf("e_rd%0d", i),    32'(bus_if.t_read_ds),     32'h0);
            step();
        end
        check("e_rel_grant", 32'(bus_if.bus_grant_out), 32'h0);
        check("e_rel_wait",  32'(bus_if.t_wait),        32'h0);
        check("e_rel_rd",    32'(bus_if.t_read_ds),     32'h1);
        clear_tdsp();
        step();
        check("e_idle_grant", 32'(bus_if.bus_grant_out), 32'h0);
        step();
        check("e_regrant", 32'(bus_if.bus_grant_out), 32'h1);

        // Asynchronous reset while the DMA owns the memory
        tdsp_acc(8'h10, 1'b1, 1'b0);
        bus_if.dma_bank = 2'd2;
        #1;
        check("f_own_wait", 32'(bus_if.t_wait), 32'h1);
        reset_n = 1'b0;
        #1;
        check("f_rst_grant", 32'(bus_if.bus_grant_out), 32'h0);
        check("f_rst_wait",  32'(bus_if.t_wait),        32'h0);
        check("f_rst_mode",  32'(bus_if.bank_mode),     32'h0);
        check("f_rst_taddr", 32'(bus_if.t_address_ds),  32'h090);
        step();
        reset_n = 1'b1;
        step();
        check("f_pend_grant", 32'(bus_if.bus_grant_out), 32'h0);
        clear_tdsp();
        step();
        check("f_own_grant", 32'(bus_if.bus_grant_out), 32'h1);
        bus_if.bus_request_in = 1'b0;
        port_wr(3'd0, 8'h01);
        check("f_drop_grant", 32'(bus_if.bus_grant_out), 32'h0);
        tdsp_acc(8'h00, 1'b1, 1'b0);
        #1;
        check("f_bank_rst", 32'(bus_if.t_address_ds), 32'h000);
        clear_tdsp();
        step();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
